// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - operand/result bundle for the bit-serial subtractor
interface serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             sout;
  logic             sout_vld;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, sout, sout_vld
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, sout, sout_vld
  );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial A-B, LSB first, JK borrow FF; SERIAL_SUB_SAT_EN clamps underflow to zero
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;

  logic a0, b0, d_bit, br_j, br_k;

  assign a0    = a_q[0];
  assign b0    = b_q[0];
  assign d_bit = a0 ^ b0 ^ br_q;
  // JK borrow: set when 0-1, clear when 1-0, otherwise hold.
  assign br_j  = ~a0 & b0;
  assign br_k  = a0 & ~b0;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    sout_d   = 1'b0;
    vld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = 1'b0;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        br_d    = (br_j & ~br_q) | (~br_k & br_q);
        sout_d  = d_bit;
        vld_d   = 1'b1;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {d_bit, res_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
`ifdef SERIAL_SUB_SAT_EN
        diff_d = br_q ? '0 : res_q;
`else
        diff_d = res_q;
`endif
        borrow_d = br_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      sout_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      sout_q   <= sout_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.sout     = sout_q;
  assign bus.sout_vld = vld_q;
endmodule
